// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code to ASCII decoder with FWFT FIFO and CapsLock LED handshake
module ps2_key_decoder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code_byte,
    input  logic       code_err,
    input  logic       rd_en,
    output logic [7:0] ascii_data,
    output logic       ascii_valid,
    output logic       fifo_ovf,
    output logic       shift_held,
    output logic       caps_lock,
    output logic       tx_req,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic       led_busy,
    output logic       led_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {P_IDLE, P_BRK, P_EXT, P_EXTBRK} pstate_t;
    typedef enum logic [2:0] {L_IDLE, L_CMD, L_ACK1, L_MASK, L_ACK2} lstate_t;

    pstate_t pstate_q;
    lstate_t lstate_q;

    logic          lshift_q, rshift_q, caps_q, caps_down_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic          pending_q;
    logic          tx_req_q, led_busy_q, led_err_q;
    logic [7:0]    tx_byte_q;
    logic [TW-1:0] ack_cnt_q;

    // An FA reply inside an ACK state belongs to the LED handshake; everything else is keyboard traffic.
    logic byte_acc, in_ack, ack_fa, key_acc;
    assign byte_acc = code_valid && !code_err;
    assign in_ack   = (lstate_q == L_ACK1) || (lstate_q == L_ACK2);
    assign ack_fa   = byte_acc && in_ack && (code_byte == 8'hFA);
    assign key_acc  = byte_acc && !ack_fa;

    logic is_make, is_break, non_key;
    assign non_key = (code_byte == 8'hFA) || (code_byte == 8'hAA) || (code_byte == 8'hEE) ||
                     (code_byte == 8'hFE) || (code_byte == 8'h00) || (code_byte == 8'hFF);

    // Classify the incoming byte as a plain make or break; extended events produce neither.
    always_comb begin
        is_make  = 1'b0;
        is_break = 1'b0;
        if (key_acc) begin
            case (pstate_q)
                P_IDLE:  is_make  = (code_byte != 8'hF0) && (code_byte != 8'hE0) && !non_key;
                P_BRK:   is_break = 1'b1;
                default: ;
            endcase
        end
    end

    // Scan code set 2 to lowercase ASCII; zero means unmapped.
    logic [7:0] map_char;
    always_comb begin
        map_char = 8'h00;
        case (code_byte)
            8'h1C: map_char = 8'h61;  8'h32: map_char = 8'h62;  8'h21: map_char = 8'h63;
            8'h23: map_char = 8'h64;  8'h24: map_char = 8'h65;  8'h2B: map_char = 8'h66;
            8'h34: map_char = 8'h67;  8'h33: map_char = 8'h68;  8'h43: map_char = 8'h69;
            8'h3B: map_char = 8'h6A;  8'h42: map_char = 8'h6B;  8'h4B: map_char = 8'h6C;
            8'h3A: map_char = 8'h6D;  8'h31: map_char = 8'h6E;  8'h44: map_char = 8'h6F;
            8'h4D: map_char = 8'h70;  8'h15: map_char = 8'h71;  8'h2D: map_char = 8'h72;
            8'h1B: map_char = 8'h73;  8'h2C: map_char = 8'h74;  8'h3C: map_char = 8'h75;
            8'h2A: map_char = 8'h76;  8'h1D: map_char = 8'h77;  8'h22: map_char = 8'h78;
            8'h35: map_char = 8'h79;  8'h1A: map_char = 8'h7A;
            8'h45: map_char = 8'h30;  8'h16: map_char = 8'h31;  8'h1E: map_char = 8'h32;
            8'h26: map_char = 8'h33;  8'h25: map_char = 8'h34;  8'h2E: map_char = 8'h35;
            8'h36: map_char = 8'h36;  8'h3D: map_char = 8'h37;  8'h3E: map_char = 8'h38;
            8'h46: map_char = 8'h39;
            8'h29: map_char = 8'h20;  8'h5A: map_char = 8'h0D;  8'h66: map_char = 8'h08;
            default: map_char = 8'h00;
        endcase
    end

    logic       map_letter, upper, fifo_push, fifo_pop, fifo_full, fifo_empty, caps_toggle;
    logic [7:0] push_data;
    assign map_letter  = (map_char >= 8'h61) && (map_char <= 8'h7A);
    assign upper       = (lshift_q || rshift_q) ^ caps_q;
    assign push_data   = (map_letter && upper) ? (map_char - 8'h20) : map_char;
    assign caps_toggle = is_make && (code_byte == 8'h58) && !caps_down_q;
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign fifo_pop    = rd_en && !fifo_empty;
    assign fifo_push   = is_make && (map_char != 8'h00) && (!fifo_full || fifo_pop);

    // Occupancy changes only when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        if (fifo_push && !fifo_pop)
            count_d = count_q + 1'b1;
        else if (fifo_pop && !fifo_push)
            count_d = count_q - 1'b1;
    end

    // Prefix tracking plus Shift and CapsLock key state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q    <= P_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_down_q <= 1'b0;
        end else begin
            if (code_valid && code_err) begin
                pstate_q <= P_IDLE;
            end else if (key_acc) begin
                case (pstate_q)
                    P_IDLE: begin
                        if (code_byte == 8'hF0)
                            pstate_q <= P_BRK;
                        else if (code_byte == 8'hE0)
                            pstate_q <= P_EXT;
                    end
                    P_EXT:   pstate_q <= (code_byte == 8'hF0) ? P_EXTBRK : P_IDLE;
                    default: pstate_q <= P_IDLE;
                endcase
            end
            if (is_make) begin
                if (code_byte == 8'h12) lshift_q <= 1'b1;
                if (code_byte == 8'h59) rshift_q <= 1'b1;
                if (caps_toggle) begin
                    caps_q      <= !caps_q;
                    caps_down_q <= 1'b1;
                end
            end
            if (is_break) begin
                if (code_byte == 8'h12) lshift_q    <= 1'b0;
                if (code_byte == 8'h59) rshift_q    <= 1'b0;
                if (code_byte == 8'h58) caps_down_q <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (fifo_push)
            mem_q[wr_ptr_q] <= push_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (is_make && (map_char != 8'h00) && fifo_full && !fifo_pop)
                ovf_q <= 1'b1;
        end
    end

    // LED handshake: ED, wait FA, mask, wait FA; reruns if CapsLock toggled while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstate_q   <= L_IDLE;
            pending_q  <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_byte_q  <= 8'h00;
            led_busy_q <= 1'b0;
            led_err_q  <= 1'b0;
            ack_cnt_q  <= '0;
        end else begin
            led_err_q <= 1'b0;
            case (lstate_q)
                L_IDLE: begin
                    if (caps_toggle || pending_q) begin
                        lstate_q   <= L_CMD;
                        tx_req_q   <= 1'b1;
                        tx_byte_q  <= 8'hED;
                        led_busy_q <= 1'b1;
                        pending_q  <= 1'b0;
                    end
                end
                L_CMD, L_MASK: begin
                    if (tx_done) begin
                        lstate_q  <= (lstate_q == L_CMD) ? L_ACK1 : L_ACK2;
                        tx_req_q  <= 1'b0;
                        ack_cnt_q <= '0;
                    end
                end
                L_ACK1, L_ACK2: begin
                    if (ack_fa) begin
                        if (lstate_q == L_ACK1) begin
                            lstate_q  <= L_MASK;
                            tx_req_q  <= 1'b1;
                            tx_byte_q <= {5'b0, caps_q, 2'b00};
                        end else begin
                            lstate_q   <= L_IDLE;
                            led_busy_q <= 1'b0;
                        end
                    end else if (byte_acc || (ack_cnt_q == TW'(ACK_TIMEOUT - 1))) begin
                        lstate_q   <= L_IDLE;
                        led_busy_q <= 1'b0;
                        led_err_q  <= 1'b1;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                default: lstate_q <= L_IDLE;
            endcase
            if (caps_toggle && (lstate_q != L_IDLE))
                pending_q <= 1'b1;
        end
    end

    assign ascii_valid = !fifo_empty;
    assign ascii_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign fifo_ovf    = ovf_q;
    assign shift_held  = lshift_q || rshift_q;
    assign caps_lock   = caps_q;
    assign tx_req      = tx_req_q;
    assign tx_byte     = tx_byte_q;
    assign led_busy    = led_busy_q;
    assign led_err     = led_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder against a keyboard reference model
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code_byte = 8'h00;
    logic       code_err = 1'b0;
    logic       rd_en = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] ascii_data, tx_byte;
    logic       ascii_valid, fifo_ovf, shift_held, caps_lock, tx_req, led_busy, led_err;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_byte(code_byte),
        .code_err(code_err), .rd_en(rd_en), .ascii_data(ascii_data), .ascii_valid(ascii_valid),
        .fifo_ovf(fifo_ovf), .shift_held(shift_held), .caps_lock(caps_lock), .tx_req(tx_req),
        .tx_byte(tx_byte), .tx_done(tx_done), .led_busy(led_busy), .led_err(led_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference keyboard model
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
        8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h35, 8'h4D, 8'h45, 8'h16, 8'h46, 8'h29,
        8'h5A, 8'h66, 8'h12, 8'h59, 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h0E, 8'hFA, 8'hAA, 8'h2B, 8'h12, 8'h59};

    logic [7:0] q [$];
    bit m_brk, m_ext, m_lsh, m_rsh, m_caps, m_capsdown, m_ovf, tb_ack;

    task automatic model_reset();
        q.delete();
        m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_capsdown = 0; m_ovf = 0;
    endtask

    function automatic logic [8:0] lookup(input logic [7:0] b, input bit up);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b) return {1'b1, (up ? 8'h41 : 8'h61) + 8'(i)};
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == b) return {1'b1, 8'h30 + 8'(i)};
        if (b == 8'h29) return {1'b1, 8'h20};
        if (b == 8'h5A) return {1'b1, 8'h0D};
        if (b == 8'h66) return {1'b1, 8'h08};
        return 9'h000;
    endfunction

    task automatic model_byte(input bit rd, input bit v, input logic [7:0] b, input bit e);
        logic [8:0] m;
        if (rd && q.size() > 0) void'(q.pop_front());
        if (!v) return;
        if (e) begin m_brk = 0; m_ext = 0; return; end
        if (tb_ack && b == 8'hFA) return;
        if (m_brk) begin
            if (!m_ext) begin
                if (b == 8'h12) m_lsh = 0;
                if (b == 8'h59) m_rsh = 0;
                if (b == 8'h58) m_capsdown = 0;
            end
            m_brk = 0; m_ext = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1; else m_ext = 0;
        end else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            m = lookup(b, (m_lsh | m_rsh) ^ m_caps);
            if (b == 8'h12) m_lsh = 1;
            if (b == 8'h59) m_rsh = 1;
            if (b == 8'h58 && !m_capsdown) begin m_caps = !m_caps; m_capsdown = 1; end
            if (m[8]) begin
                if (q.size() < DEPTH) q.push_back(m[7:0]); else m_ovf = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, entered and left on a falling edge
    task automatic cyc(input bit rd, input bit v, input logic [7:0] b, input bit e);
        rd_en = rd; code_valid = v; code_byte = b; code_err = e;
        model_byte(rd, v, b, e);
        @(negedge clk);
        rd_en = 0; code_valid = 0; code_err = 0;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(0, 1, b, 0);
    endtask

    task automatic ack(input logic [7:0] b);
        tb_ack = 1; send(b); tb_ack = 0;
    endtask

    task automatic done_pulse();
        tx_done = 1; @(negedge clk); tx_done = 0;
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, ascii_valid, q.size() != 0);
        if (q.size() != 0) check({tag, "_data"}, ascii_data, q[0]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ascii_valid"}, ascii_valid, 0);
        check({tag, "_ascii_data"}, ascii_data, 0);
        check({tag, "_ovf"}, fifo_ovf, 0);
        check({tag, "_shift"}, shift_held, 0);
        check({tag, "_caps"}, caps_lock, 0);
        check({tag, "_tx_req"}, tx_req, 0);
        check({tag, "_tx_byte"}, tx_byte, 0);
        check({tag, "_busy"}, led_busy, 0);
        check({tag, "_err"}, led_err, 0);
    endtask

    task automatic caps_press();
        send(8'h58); send(8'hF0); send(8'h58);
    endtask

    int n;
    bit seen;

    initial begin
        tb_ack = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        check_all_zero("reset");

        // Test 1: single make, latency, shifted letter
        code_valid = 1; code_byte = 8'h1C; model_byte(0, 1, 8'h1C, 0);
        #1 check("t1_pre_edge_valid", ascii_valid, 0);
        @(negedge clk); code_valid = 0;
        check("t1_a_valid", ascii_valid, 1);
        check("t1_a_data", ascii_data, 8'h61);
        cyc(1, 0, 0, 0);
        send(8'h12);
        check("t1_shift_down", shift_held, 1);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        check("t1_A_data", ascii_data, 8'h41);
        check("t1_shift_up", shift_held, 0);
        cyc(1, 0, 0, 0);
        check("t1_empty", ascii_valid, 0);

        // Test 2: CapsLock with full LED handshake, then repeats give one toggle
        send(8'h58);
        check("t2_caps_on", caps_lock, 1);
        check("t2_tx_req", tx_req, 1);
        check("t2_tx_byte_ed", tx_byte, 8'hED);
        check("t2_busy", led_busy, 1);
        send(8'hF0); send(8'h58);
        done_pulse();
        check("t2_tx_req_drop", tx_req, 0);
        ack(8'hFA);
        check("t2_mask_req", tx_req, 1);
        check("t2_mask_04", tx_byte, 8'h04);
        done_pulse();
        ack(8'hFA);
        check("t2_idle", led_busy, 0);
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        check("t2_caps_off", caps_lock, m_caps);
        check("t2_caps_off_const", caps_lock, 0);
        done_pulse(); ack(8'hFA);
        check("t2_mask_00", tx_byte, 8'h00);
        done_pulse(); ack(8'hFA);
        check("t2_idle2", led_busy, 0);
        check("t2_no_ascii", ascii_valid, 0);

        // Test 3: extended make/break ignored
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h1C);
        check_head("t3_head");
        check("t3_a", ascii_data, 8'h61);
        cyc(1, 0, 0, 0);
        check("t3_one_entry", ascii_valid, 0);
        check("t3_shift", shift_held, 0);
        check("t3_caps", caps_lock, 0);

        // Test 4: overflow, then full with simultaneous pop and push
        for (int i = 0; i <= DEPTH; i++) send(letter_codes[$urandom_range(25)]);
        check("t4_ovf", fifo_ovf, 1);
        check("t4_model_ovf", fifo_ovf, m_ovf);
        cyc(1, 1, 8'h16, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check_head("t4_drain");
            cyc(1, 0, 0, 0);
        end
        check("t4_empty_after_8", ascii_valid, 0);
        cyc(1, 0, 0, 0);
        check("t4_empty_pop_ignored", ascii_valid, 0);

        // Test 5: bad reply and timeout in the ACK states
        caps_press();
        done_pulse();
        ack(8'hFE);
        check("t5_err_pulse", led_err, 1);
        check("t5_err_idle", led_busy, 0);
        cyc(0, 0, 0, 0);
        check("t5_err_one_cycle", led_err, 0);
        caps_press();
        done_pulse();
        n = 0; seen = 0;
        while (n < TMO + 20 && !seen) begin
            @(negedge clk); n++;
            seen = led_err;
        end
        check("t5_timeout_seen", seen, 1);
        check("t5_timeout_cycles", n, TMO);
        check("t5_timeout_idle", led_busy, 0);
        check("t5_caps", caps_lock, m_caps);

        // Test 7: toggle while busy reruns with latest caps value
        caps_press();
        caps_press();
        check("t7_caps_latest", caps_lock, 0);
        done_pulse(); ack(8'hFA);
        check("t7_first_mask", tx_byte, 8'h00);
        done_pulse(); ack(8'hFA);
        cyc(0, 0, 0, 0);
        check("t7_rerun_busy", led_busy, 1);
        check("t7_rerun_ed", tx_byte, 8'hED);
        done_pulse(); ack(8'hFA);
        check("t7_rerun_mask", tx_byte, 8'h00);
        done_pulse(); ack(8'hFA);
        check("t7_done", led_busy, 0);

        // Test 6: code_err after F0 aborts the break; reset mid-mask
        send(8'hF0);
        cyc(0, 1, 8'h1C, 1);
        send(8'h1C);
        check_head("t6_head");
        check("t6_a", ascii_data, 8'h61);
        caps_press();
        done_pulse(); ack(8'hFA);
        check("t6_in_mask", tx_byte, 8'h04);
        #2 rst_n = 0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk); rst_n = 1;
        check_all_zero("after_rst");

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            check_head("rnd");
            cyc($urandom_range(2) == 0, $urandom_range(3) != 0, pool[$urandom_range(23)],
                $urandom_range(15) == 0);
        end
        check("rnd_shift", shift_held, m_lsh | m_rsh);
        check("rnd_ovf", fifo_ovf, m_ovf);
        check("rnd_caps", caps_lock, 0);
        check("rnd_busy", led_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
